alu_all_reg: RTL and testbench



---
 rtl/alu_all_reg.sv | 124 ++++++++++++
 tb/tb_alu_all_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_all_reg.sv
// 8-bit registered ALU: ripple add-with-carry, ripple subtract-with-borrow, AND, OR.
// Optional registered zero flag when ALU_ALL_ZERO_FLAG_EN is defined.

module alu_all_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module alu_all_fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module alu_all_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [1:0] sel,
`ifdef ALU_ALL_ZERO_FLAG_EN
    output logic       zero,
`endif
    output logic [7:0] out,
    output logic       cout
);
    localparam int W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    logic [W:0]   carry;
    logic [W:0]   borrow;
    logic [W-1:0] sum;
    logic [W-1:0] diff;

    logic [W-1:0] out_d, out_q;
    logic         cout_d, cout_q;

    assign carry[0]  = cin;
    assign borrow[0] = cin;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        alu_all_fa_cell u_fa (
            .a_i (a[gi]),
            .b_i (b[gi]),
            .c_i (carry[gi]),
            .s_o (sum[gi]),
            .c_o (carry[gi+1])
        );
        alu_all_fs_cell u_fs (
            .a_i    (a[gi]),
            .b_i    (b[gi]),
            .bin_i  (borrow[gi]),
            .d_o    (diff[gi]),
            .bout_o (borrow[gi+1])
        );
    end

    // Logic ops force cout to a constant so an undriven cin never leaks through.
    always_comb begin
        out_d  = '0;
        cout_d = 1'b0;
        case (op_e'(sel))
            OP_ADD: begin
                out_d  = sum;
                cout_d = carry[W];
            end
            OP_SUB: begin
                out_d  = diff;
                cout_d = borrow[W];
            end
            OP_AND: out_d = a & b;
            OP_OR:  out_d = a | b;
            default: begin
                out_d  = '0;
                cout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;

`ifdef ALU_ALL_ZERO_FLAG_EN
    logic zero_d, zero_q;

    assign zero_d = (out_d == '0);

    always_ff @(posedge clk) begin
        if (rst) zero_q <= 1'b1;
        else     zero_q <= zero_d;
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_all_reg.sv
// Scoreboard bench for alu_all_reg: directed cases, strided pipelined sweep, mid-stream reset.
// Follows ALU_ALL_ZERO_FLAG_EN so the zero flag is checked when the feature is built.

module tb_alu_all_reg;
    typedef struct packed {
        logic [7:0] out;
        logic       cout;
`ifdef ALU_ALL_ZERO_FLAG_EN
        logic       zero;
`endif
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       cin = 1'b0;
    logic [1:0] sel = '0;
    logic [7:0] out;
    logic       cout;
`ifdef ALU_ALL_ZERO_FLAG_EN
    logic       zero;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t last_exp;
    bit   have_last = 1'b0;

    always #5 clk = ~clk;

    alu_all_reg dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sel  (sel),
`ifdef ALU_ALL_ZERO_FLAG_EN
        .zero (zero),
`endif
        .out  (out),
        .cout (cout)
    );

    function automatic res_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic cv, input logic [1:0] sv, input logic rv);
        res_t       r;
        logic [8:0] t;
        r = '0;
        t = '0;
        if (!rv) begin
            case (sv)
                2'b00: begin
                    t = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
                    r.out  = t[7:0];
                    r.cout = t[8];
                end
                2'b01: begin
                    r.out  = av - bv - {7'b0, cv};
                    r.cout = ({1'b0, av} < ({1'b0, bv} + {8'b0, cv}));
                end
                2'b10: r.out = av & bv;
                default: r.out = av | bv;
            endcase
        end
`ifdef ALU_ALL_ZERO_FLAG_EN
        r.zero = (r.out == 8'h00);
`endif
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r = '0;
        r.out  = out;
        r.cout = cout;
`ifdef ALU_ALL_ZERO_FLAG_EN
        r.zero = zero;
`endif
        return r;
    endfunction

    // Drive one operation, confirm outputs hold while inputs change, then check the result.
    task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [1:0] sv, input logic rv, input string tag);
        res_t exp_r;
        res_t obs;
        a = av; b = bv; cin = cv; sel = sv; rst = rv;
        sb_q.push_back(model(av, bv, cv, sv, rv));
        #1;
        if (have_last) begin
            obs = observed();
            checks++;
            assert (obs === last_exp) else begin
                errors++;
                $error("FAIL %s_hold: got %h expected %h", tag, obs, last_exp);
            end
        end
        @(posedge clk);
        #1;
        obs = observed();
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: got %h expected <scoreboard empty>", tag, obs);
        end else begin
            exp_r = sb_q.pop_front();
            assert (obs === exp_r) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", tag, obs, exp_r);
            end
            last_exp  = exp_r;
            have_last = 1'b1;
        end
    endtask

    logic [7:0] btab [16];

    initial begin
        btab = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h3C, 8'h55, 8'h7F,
                 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF, 8'h5A};

        step(8'hAA, 8'h55, 1'b0, 2'b00, 1'b1, "reset0");
        step(8'hAA, 8'h55, 1'b0, 2'b00, 1'b1, "reset1");

        step(8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, "add_carry");
        step(8'h12, 8'h34, 1'b1, 2'b00, 1'b0, "add_cin");
        step(8'hFF, 8'h00, 1'b1, 2'b00, 1'b0, "add_ff_cin");
        step(8'h05, 8'h03, 1'b0, 2'b01, 1'b0, "sub_simple");
        step(8'h00, 8'h00, 1'b1, 2'b01, 1'b0, "sub_bin_wrap");
        step(8'h10, 8'h20, 1'b0, 2'b01, 1'b0, "sub_borrow");
        step(8'hF0, 8'h3C, 1'b1, 2'b10, 1'b0, "and_cin1");
        step(8'hF0, 8'h3C, 1'b1, 2'b11, 1'b0, "or_cin1");
        step(8'h0F, 8'hF0, 1'b1, 2'b10, 1'b0, "and_zero");

        for (int i = 0; i < 16; i++)
            step(8'(i * 37), btab[i], i[0], i[1:0], 1'b0, "b2b");

        // Strided sweep: every a, sel and cin against a table of b values, one op per cycle.
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 2; c++)
                for (int bi = 0; bi < 16; bi++)
                    for (int ai = 0; ai < 256; ai++) begin
                        if (s == 1 && c == 1 && bi == 7 && ai == 100)
                            step(8'(ai), btab[bi], c[0], s[1:0], 1'b1, "mid_reset");
                        else
                            step(8'(ai), btab[bi], c[0], s[1:0], 1'b0, "sweep");
                    end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
